// File: rtl/ace_ccu_snoop_fanout.sv
// ace_ccu_snoop_fanout
//   Fans one upstream ACE snoop (AC) out to a masked set of cache snoop ports,
//   OR-merges their snoop responses (CR) into a single upstream CR, then
//   forwards the CD line of the lowest-indexed port that signalled
//   DataTransfer while draining and discarding CD lines from any other
//   ports that also signalled DataTransfer. Only one snoop is in flight.
//
// Ports
//   clk_i, rst_i              clock, asynchronous active-high reset
//   slv_req_*_i               upstream AC payload/valid, CR ready, CD ready
//   slv_resp_*_o              upstream AC ready, merged CR, forwarded CD
//   slv_mask_i                target port mask, sampled with the AC handshake
//   mst_reqs_*_o              per-port AC payload (packed) and valid, CR/CD ready
//   mst_resps_*_i             per-port AC ready, CR valid/resp, CD valid/data/last
module ace_ccu_snoop_fanout #(
  parameter int unsigned NoMstPorts  = 4,
  parameter int unsigned AcWidth     = 44,
  parameter int unsigned CdDataWidth = 64
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [AcWidth-1:0]                slv_req_ac_i,
  input  logic                              slv_req_ac_valid_i,
  input  logic                              slv_req_cr_ready_i,
  input  logic                              slv_req_cd_ready_i,
  output logic                              slv_resp_ac_ready_o,
  output logic                              slv_resp_cr_valid_o,
  output logic [4:0]                        slv_resp_cr_resp_o,
  output logic                              slv_resp_cd_valid_o,
  output logic [CdDataWidth-1:0]            slv_resp_cd_data_o,
  output logic                              slv_resp_cd_last_o,
  input  logic [NoMstPorts-1:0]             slv_mask_i,
  output logic [NoMstPorts*AcWidth-1:0]     mst_reqs_ac_o,
  output logic [NoMstPorts-1:0]             mst_reqs_ac_valid_o,
  output logic [NoMstPorts-1:0]             mst_reqs_cr_ready_o,
  output logic [NoMstPorts-1:0]             mst_reqs_cd_ready_o,
  input  logic [NoMstPorts-1:0]             mst_resps_ac_ready_i,
  input  logic [NoMstPorts-1:0]             mst_resps_cr_valid_i,
  input  logic [NoMstPorts*5-1:0]           mst_resps_cr_resp_i,
  input  logic [NoMstPorts-1:0]             mst_resps_cd_valid_i,
  input  logic [NoMstPorts*CdDataWidth-1:0] mst_resps_cd_data_i,
  input  logic [NoMstPorts-1:0]             mst_resps_cd_last_i
);

  typedef enum logic [2:0] {IDLE, BCAST, COLLECT, RESP, DATA} state_t;

  state_t                  state_q, state_d;
  logic [AcWidth-1:0]      ac_q;
  logic [NoMstPorts-1:0]   mask_q, ac_done_q, cr_done_q, dt_mask_q, cd_done_q;
  logic [4:0]              cr_q, cr_merge;
  logic [NoMstPorts-1:0]   ac_hs, cr_hs, cd_last_hs, dt_new, src_oh, drain;

  // Every port sees the same latched snoop; only ac_valid is per-port.
  assign mst_reqs_ac_o = {NoMstPorts{ac_q}};

  // Source of the forwarded line: lowest-indexed DataTransfer port.
  always_comb begin
    logic found;
    found  = 1'b0;
    src_oh = '0;
    for (int unsigned i = 0; i < NoMstPorts; i++) begin
      if (dt_mask_q[i] && !found) begin
        src_oh[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign drain = dt_mask_q & ~src_oh;

  // Merge all CRs accepted this cycle; several ports may complete together.
  always_comb begin
    cr_merge = cr_q;
    dt_new   = '0;
    for (int unsigned i = 0; i < NoMstPorts; i++) begin
      if (cr_hs[i]) begin
        cr_merge  = cr_merge | mst_resps_cr_resp_i[i*5 +: 5];
        dt_new[i] = mst_resps_cr_resp_i[i*5];
      end
    end
  end

  always_comb begin
    state_d             = state_q;
    slv_resp_ac_ready_o = 1'b0;
    slv_resp_cr_valid_o = 1'b0;
    slv_resp_cr_resp_o  = '0;
    slv_resp_cd_valid_o = 1'b0;
    slv_resp_cd_data_o  = '0;
    slv_resp_cd_last_o  = 1'b0;
    mst_reqs_ac_valid_o = '0;
    mst_reqs_cr_ready_o = '0;
    mst_reqs_cd_ready_o = '0;
    ac_hs               = '0;
    cr_hs               = '0;
    cd_last_hs          = '0;
    case (state_q)
      IDLE: begin
        // Gated so ac_ready is low for the whole reset pulse.
        slv_resp_ac_ready_o = ~rst_i;
        if (slv_req_ac_valid_i) begin
          state_d = (slv_mask_i == '0) ? RESP : BCAST;
        end
      end
      BCAST: begin
        mst_reqs_ac_valid_o = mask_q & ~ac_done_q;
        ac_hs               = mst_reqs_ac_valid_o & mst_resps_ac_ready_i;
        if ((ac_done_q | ac_hs) == mask_q) state_d = COLLECT;
      end
      COLLECT: begin
        mst_reqs_cr_ready_o = mask_q & ~cr_done_q;
        cr_hs               = mst_reqs_cr_ready_o & mst_resps_cr_valid_i;
        if ((cr_done_q | cr_hs) == mask_q) state_d = RESP;
      end
      RESP: begin
        slv_resp_cr_valid_o = 1'b1;
        slv_resp_cr_resp_o  = cr_q;
        if (slv_req_cr_ready_i) begin
          state_d = (dt_mask_q == '0) ? IDLE : DATA;
        end
      end
      DATA: begin
        for (int unsigned i = 0; i < NoMstPorts; i++) begin
          if (src_oh[i]) begin
            slv_resp_cd_valid_o    = mst_resps_cd_valid_i[i] & ~cd_done_q[i];
            slv_resp_cd_data_o     = mst_resps_cd_data_i[i*CdDataWidth +: CdDataWidth];
            slv_resp_cd_last_o     = mst_resps_cd_last_i[i];
            mst_reqs_cd_ready_o[i] = slv_req_cd_ready_i & ~cd_done_q[i];
          end else begin
            mst_reqs_cd_ready_o[i] = drain[i] & ~cd_done_q[i];
          end
        end
        cd_last_hs = mst_reqs_cd_ready_o & mst_resps_cd_valid_i & mst_resps_cd_last_i;
        if ((cd_done_q | cd_last_hs) == dt_mask_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake vectors are zero outside their own state, so the done/merge
  // registers can accumulate unconditionally between snoops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ac_q      <= '0;
      mask_q    <= '0;
      ac_done_q <= '0;
      cr_done_q <= '0;
      dt_mask_q <= '0;
      cd_done_q <= '0;
      cr_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && slv_req_ac_valid_i) begin
        ac_q      <= slv_req_ac_i;
        mask_q    <= slv_mask_i;
        ac_done_q <= '0;
        cr_done_q <= '0;
        dt_mask_q <= '0;
        cd_done_q <= '0;
        cr_q      <= '0;
      end else begin
        ac_done_q <= ac_done_q | ac_hs;
        cr_done_q <= cr_done_q | cr_hs;
        dt_mask_q <= dt_mask_q | dt_new;
        cd_done_q <= cd_done_q | cd_last_hs;
        cr_q      <= cr_merge;
      end
    end
  end

endmodule

// File: tb/tb_ace_ccu_snoop_fanout.sv
// Testbench for ace_ccu_snoop_fanout: the bench plays upstream and the caches,
// predicts merged CR, forwarded CD beats and drained ports from the snoop rules.
module tb_ace_ccu_snoop_fanout;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = 44;
  localparam int unsigned DW = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [AW-1:0]   slv_ac;
  logic            slv_ac_valid, slv_cr_ready, slv_cd_ready;
  logic            slv_ac_ready, slv_cr_valid, slv_cd_valid, slv_cd_last;
  logic [4:0]      slv_cr_resp;
  logic [DW-1:0]   slv_cd_data;
  logic [N-1:0]    slv_mask;
  logic [N*AW-1:0] mst_ac;
  logic [N-1:0]    mst_ac_valid, mst_cr_ready, mst_cd_ready;
  logic [N-1:0]    mst_ac_ready, mst_cr_valid, mst_cd_valid, mst_cd_last;
  logic [N*5-1:0]  mst_cr_resp;
  logic [N*DW-1:0] mst_cd_data;

  ace_ccu_snoop_fanout #(.NoMstPorts(N), .AcWidth(AW), .CdDataWidth(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .slv_req_ac_i(slv_ac), .slv_req_ac_valid_i(slv_ac_valid),
    .slv_req_cr_ready_i(slv_cr_ready), .slv_req_cd_ready_i(slv_cd_ready),
    .slv_resp_ac_ready_o(slv_ac_ready), .slv_resp_cr_valid_o(slv_cr_valid),
    .slv_resp_cr_resp_o(slv_cr_resp), .slv_resp_cd_valid_o(slv_cd_valid),
    .slv_resp_cd_data_o(slv_cd_data), .slv_resp_cd_last_o(slv_cd_last),
    .slv_mask_i(slv_mask),
    .mst_reqs_ac_o(mst_ac), .mst_reqs_ac_valid_o(mst_ac_valid),
    .mst_reqs_cr_ready_o(mst_cr_ready), .mst_reqs_cd_ready_o(mst_cd_ready),
    .mst_resps_ac_ready_i(mst_ac_ready), .mst_resps_cr_valid_i(mst_cr_valid),
    .mst_resps_cr_resp_i(mst_cr_resp), .mst_resps_cd_valid_i(mst_cd_valid),
    .mst_resps_cd_data_i(mst_cd_data), .mst_resps_cd_last_i(mst_cd_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-port cache behaviour for the next snoop.
  logic [4:0]    cr_val   [N];
  int            ac_delay [N];
  int            cr_delay [N];
  logic [DW-1:0] cd_dat   [N][4];
  logic [AW-1:0] ac_val;

  task automatic clear_inputs();
    slv_ac = '0; slv_ac_valid = 1'b0; slv_cr_ready = 1'b0; slv_cd_ready = 1'b0;
    slv_mask = '0; mst_ac_ready = '0; mst_cr_valid = '0; mst_cr_resp = '0;
    mst_cd_valid = '0; mst_cd_data = '0; mst_cd_last = '0;
  endtask

  task automatic setup_port(input int i, input logic [4:0] crv, input int acd, input int crd);
    cr_val[i]   = crv;
    ac_delay[i] = acd;
    cr_delay[i] = crd;
    for (int b = 0; b < 4; b++) cd_dat[i][b] = {$urandom, $urandom};
  endtask

  // One complete snoop. With abort set, upstream never accepts CD and reset
  // is pulsed as soon as the forwarded line is offered upstream.
  task automatic run_snoop(input logic [N-1:0] mask, input bit abort, input string tag);
    int ac_wait [N]; int cr_cnt [N]; int cd_idx [N]; int ac_vcnt [N];
    bit ac_done [N]; bit cr_done [N]; bit cd_pend [N];
    bit ac_acc, cr_got, fin, all_ac;
    int cyc, hs_cyc, first_ac, first_cr, beats, src;
    logic [4:0]    exp_cr;
    logic [N-1:0]  dt_exp, stray, drained, crd_vec;
    logic [63:0]   r64;
    for (int i = 0; i < N; i++) begin
      ac_wait[i] = 0; cr_cnt[i] = 0; cd_idx[i] = 0; ac_vcnt[i] = 0;
      ac_done[i] = 0; cr_done[i] = 0; cd_pend[i] = 0;
    end
    ac_acc = 0; cr_got = 0; fin = 0;
    cyc = 0; hs_cyc = -100; first_ac = -1; first_cr = -1; beats = 0;
    // Reference: OR of masked CRs; lowest DataTransfer port is the source.
    exp_cr = '0; dt_exp = '0; src = -1;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        exp_cr = exp_cr | cr_val[i];
        if (cr_val[i][0]) dt_exp[i] = 1'b1;
      end
    end
    for (int i = N - 1; i >= 0; i--) if (dt_exp[i]) src = i;

    @(negedge clk);
    r64 = {$urandom, $urandom};
    ac_val = r64[AW-1:0];
    slv_ac = ac_val;
    slv_mask = mask;
    while (!fin) begin
      slv_ac_valid = !ac_acc;
      for (int i = 0; i < N; i++) begin
        mst_ac_ready[i] = (ac_wait[i] >= ac_delay[i]);
        mst_cr_valid[i] = ac_done[i] && !cr_done[i] && (cr_cnt[i] >= cr_delay[i]);
        mst_cr_resp[i*5 +: 5] = mst_cr_valid[i] ? cr_val[i] : 5'h1f;
        if (dt_exp[i] && ac_done[i] && cd_idx[i] < 4) begin
          if (!cd_pend[i]) cd_pend[i] = ($urandom_range(0, 3) != 0);
          mst_cd_valid[i] = cd_pend[i];
          mst_cd_data[i*DW +: DW] = cd_dat[i][cd_idx[i]];
          mst_cd_last[i] = (cd_idx[i] == 3);
        end else begin
          mst_cd_valid[i] = 1'b0;
          mst_cd_data[i*DW +: DW] = '0;
          mst_cd_last[i] = 1'b0;
        end
      end
      slv_cr_ready = 1'($urandom_range(0, 1));
      slv_cd_ready = abort ? 1'b0 : 1'($urandom_range(0, 1));
      #1;
      // Valid/ready may only appear on ports the snoop actually targets.
      stray = (mst_ac_valid & ~mask) | (mst_cr_ready & ~mask) | (mst_cd_ready & ~dt_exp);
      checks++;
      if (stray !== '0)
        $display("FAIL %s stray_handshake: got %b required %b (cyc %0d)", tag, stray, {N{1'b0}}, cyc);
      all_ac = 1;
      for (int i = 0; i < N; i++) if (mask[i] && !ac_done[i]) all_ac = 0;
      for (int i = 0; i < N; i++) begin
        if (mst_ac_valid[i]) begin
          checks++;
          if (mst_ac[i*AW +: AW] !== ac_val || ac_done[i]) begin
            errors++;
            $display("FAIL %s ac_port%0d: got ac %h done %0d required ac %h done 0",
                     tag, i, mst_ac[i*AW +: AW], ac_done[i], ac_val);
          end
        end
        if (mst_cr_ready[i]) begin
          checks++;
          if (!all_ac) begin
            errors++;
            $display("FAIL %s cr_early_port%0d: got cr_ready 1 required 0 before all AC done", tag, i);
          end
        end
      end
      if (stray !== '0) errors++;
      if (slv_cr_valid && first_cr < 0) first_cr = cyc;
      if (slv_cr_valid && slv_cr_ready) begin
        checks++;
        if (slv_cr_resp !== exp_cr || cr_got) begin
          errors++;
          $display("FAIL %s cr_resp: got %b (repeat %0d) required %b", tag, slv_cr_resp, cr_got, exp_cr);
        end
      end
      if (slv_cd_valid) begin
        checks++;
        if (!cr_got) begin
          errors++;
          $display("FAIL %s cd_before_cr: got cd_valid 1 required 0", tag);
        end
      end
      if (abort && slv_cd_valid) begin
        rst = 1'b1;
        #1;
        checks++;
        if ({slv_ac_ready, slv_cr_valid, slv_cd_valid, mst_ac_valid, mst_cr_ready, mst_cd_ready} !== '0) begin
          errors++;
          $display("FAIL %s reset_mid: got %b required all zero", tag,
                   {slv_ac_ready, slv_cr_valid, slv_cd_valid, mst_ac_valid, mst_cr_ready, mst_cd_ready});
        end
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        fin = 1;
      end else begin
        if (slv_cd_valid && slv_cd_ready) begin
          checks++;
          if (src < 0 || beats >= 4) begin
            errors++;
            $display("FAIL %s cd_extra: got beat %0d required at most 4 beats from port %0d", tag, beats, src);
          end else if ({slv_cd_data, slv_cd_last} !== {cd_dat[src][beats], (beats == 3)}) begin
            errors++;
            $display("FAIL %s cd_beat%0d: got %h last %0d required %h last %0d", tag, beats,
                     slv_cd_data, slv_cd_last, cd_dat[src][beats], (beats == 3));
          end
          beats++;
        end
        if (ac_acc && cr_got && slv_ac_ready) fin = 1;
        if (slv_ac_valid && slv_ac_ready) begin ac_acc = 1; hs_cyc = cyc; end
        if ((|mst_ac_valid) && first_ac < 0) first_ac = cyc;
        for (int i = 0; i < N; i++) begin
          if (ac_done[i]) cr_cnt[i]++;
          if (mst_ac_valid[i]) begin
            ac_vcnt[i]++;
            if (mst_ac_ready[i]) ac_done[i] = 1; else ac_wait[i]++;
          end
          if (mst_cr_valid[i] && mst_cr_ready[i]) cr_done[i] = 1;
          if (mst_cd_valid[i] && mst_cd_ready[i]) begin cd_idx[i]++; cd_pend[i] = 0; end
        end
        if (slv_cr_valid && slv_cr_ready) cr_got = 1;
        cyc++;
        if (cyc > 400 && !fin) begin
          checks++; errors++;
          $display("FAIL %s timeout: got no return to IDLE required within 400 cycles", tag);
          fin = 1;
        end
        if (!fin) @(negedge clk);
      end
    end
    clear_inputs();
    if (!abort) begin
      checks++;
      if (mask != '0 && first_ac - hs_cyc != 1) begin
        errors++;
        $display("FAIL %s ac_latency: got %0d required 1", tag, first_ac - hs_cyc);
      end else if (mask == '0 && first_cr - hs_cyc != 1) begin
        errors++;
        $display("FAIL %s cr_latency: got %0d required 1", tag, first_cr - hs_cyc);
      end
      checks++;
      if (beats != ((src >= 0) ? 4 : 0)) begin
        errors++;
        $display("FAIL %s cd_beats: got %0d required %0d", tag, beats, (src >= 0) ? 4 : 0);
      end
      drained = '0; crd_vec = '0;
      for (int i = 0; i < N; i++) begin
        drained[i] = (cd_idx[i] == 4);
        crd_vec[i] = cr_done[i];
      end
      checks++;
      if (drained !== dt_exp || crd_vec !== mask) begin
        errors++;
        $display("FAIL %s completion: got cd %b cr %b required cd %b cr %b", tag, drained, crd_vec, dt_exp, mask);
      end
      for (int i = 0; i < N; i++) begin
        checks++;
        if (ac_vcnt[i] != (mask[i] ? ac_delay[i] + 1 : 0)) begin
          errors++;
          $display("FAIL %s ac_valid_cycles_port%0d: got %0d required %0d", tag, i, ac_vcnt[i],
                   mask[i] ? ac_delay[i] + 1 : 0);
        end
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    slv_ac_valid = 1'b1; mst_ac_ready = '1; mst_cr_valid = '1; mst_cd_valid = '1;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({slv_ac_ready, slv_cr_valid, slv_cd_valid, mst_ac_valid, mst_cr_ready, mst_cd_ready} !== '0
        || mst_ac !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready/valid %b ac %h required all zero", {slv_ac_ready,
               slv_cr_valid, slv_cd_valid, mst_ac_valid, mst_cr_ready, mst_cd_ready}, mst_ac);
    end
    clear_inputs();
    rst = 1'b0;
    #1;
    checks++;
    if ({slv_ac_ready, slv_cr_valid, slv_cd_valid} !== 3'b100) begin
      errors++;
      $display("FAIL reset_idle: got %b required 100", {slv_ac_ready, slv_cr_valid, slv_cd_valid});
    end
  endtask

  task automatic test_no_data();
    for (int i = 0; i < N; i++) setup_port(i, 5'b00000, 0, 0);
    run_snoop(4'b0101, 1'b0, "no_data");
  endtask

  task automatic test_ac_stall();
    for (int i = 0; i < N; i++) setup_port(i, 5'b00000, 0, 0);
    ac_delay[0] = 3;
    run_snoop(4'b0101, 1'b0, "ac_stall");
  endtask

  task automatic test_data_merge();
    for (int i = 0; i < N; i++) setup_port(i, 5'b11111, 0, 1);
    setup_port(0, 5'b01000, 1, 2);
    setup_port(2, 5'b00101, 0, 0);
    run_snoop(4'b0101, 1'b0, "data_merge");
  endtask

  task automatic test_drain();
    for (int i = 0; i < N; i++) setup_port(i, 5'b00000, 0, 0);
    setup_port(0, 5'b00001, 0, 1);
    setup_port(2, 5'b10001, 2, 0);
    run_snoop(4'b0101, 1'b0, "drain");
  endtask

  task automatic test_mask_zero();
    for (int i = 0; i < N; i++) setup_port(i, 5'($urandom), 0, 0);
    run_snoop(4'b0000, 1'b0, "mask_zero");
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++)
        setup_port(i, 5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      run_snoop(4'($urandom), 1'b0, "random");
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < N; i++) setup_port(i, 5'b00000, 0, 0);
    setup_port(0, 5'b00011, 0, 0);
    setup_port(3, 5'b00001, 1, 1);
    run_snoop(4'b1001, 1'b1, "reset_mid");
    for (int i = 0; i < N; i++) setup_port(i, 5'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
    cr_val[1] = 5'b00001;
    run_snoop(4'b1110, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_no_data();
    test_ac_stall();
    test_data_merge();
    test_drain();
    test_mask_zero();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
